instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit feeding branch/decode (optional halt opcode via IFETCH_HALT_EN)
module instr_fetch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [7:0]  pc,
   output logic [7:0]  npc
`ifdef IFETCH_HALT_EN
   ,
   output logic        halted
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_HALT = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [7:0] fetch_pc;
   logic       do_redirect;
   logic       take_ack;
   logic       consume;

   // Redirect is honoured everywhere except the single post-reset IDLE cycle.
   assign do_redirect = redirect && (state != S_IDLE);
   assign take_ack    = (state == S_REQ) && imem_ack && !redirect;
   assign consume     = (state == S_HOLD) && !stall && !redirect;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; redirect always returns to REQ with the new target.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            if (redirect)      state_nxt = S_REQ;
            else if (imem_ack) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (redirect) state_nxt = S_REQ;
            else if (!stall) begin
`ifdef IFETCH_HALT_EN
               if (instr[15:11] == 5'b11111) state_nxt = S_HALT;
               else                          state_nxt = S_REQ;
`else
               state_nxt = S_REQ;
`endif
            end
         end
         S_HALT: begin
            if (redirect) state_nxt = S_REQ;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs: request only in REQ; address always reflects fetch_pc.
   always_comb begin
      imem_req  = (state == S_REQ);
      imem_addr = fetch_pc;
   end

   // Fetch pointer and presented instruction; ack data in a redirect cycle is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= 8'h00;
         instr       <= 16'h0000;
         pc          <= 8'h00;
         npc         <= 8'h01;
         instr_valid <= 1'b0;
      end else if (do_redirect) begin
         fetch_pc    <= redirect_pc;
         instr_valid <= 1'b0;
      end else if (take_ack) begin
         instr       <= imem_rdata;
         pc          <= fetch_pc;
         npc         <= fetch_pc + 8'd1;
         instr_valid <= 1'b1;
         fetch_pc    <= fetch_pc + 8'd1;
      end else if (consume) begin
         instr_valid <= 1'b0;
      end
   end

`ifdef IFETCH_HALT_EN
   // Halt flag: set when a halt opcode is consumed, cleared only by redirect or reset.
   always_ff @(posedge clk) begin
      if (!rst_n)                                  halted <= 1'b0;
      else if (do_redirect)                        halted <= 1'b0;
      else if (consume && instr[15:11] == 5'b11111) halted <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic [7:0]  pc;
   logic [7:0]  npc;
`ifdef IFETCH_HALT_EN
   logic        halted;
`endif

   // Memory model: single-cycle ack to each request, data = A000 + address.
   logic        ack_en = 1'b0;
   logic        force_ack = 1'b0;
   logic        ovr_en = 1'b0;
   logic [15:0] ovr_data = 16'h0000;

   assign imem_ack   = force_ack | (ack_en & imem_req);
   assign imem_rdata = ovr_en ? ovr_data : (16'hA000 + {8'h00, imem_addr});

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .npc         (npc)
`ifdef IFETCH_HALT_EN
      ,
      .halted      (halted)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] i,
                          input logic [7:0] p, input logic [7:0] n, input logic rq,
                          input logic [7:0] a);
      chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
      chk({tag, ".instr"}, {16'd0, instr}, {16'd0, i});
      chk({tag, ".pc"}, {24'd0, pc}, {24'd0, p});
      chk({tag, ".npc"}, {24'd0, npc}, {24'd0, n});
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, rq});
      chk({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, a});
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk_out("reset", 1'b0, 16'h0000, 8'h00, 8'h01, 1'b0, 8'h00);

      // Release: one IDLE cycle, then REQ
      rst_n = 1'b1;
      ack_en = 1'b1;
      #1;
      chk("idle.req", {31'd0, imem_req}, 32'd0);
      tick();
      chk_out("req0", 1'b0, 16'h0000, 8'h00, 8'h01, 1'b1, 8'h00);

      // Sequential fetch with single-cycle memory
      tick();
      chk_out("f0", 1'b1, 16'hA000, 8'h00, 8'h01, 1'b0, 8'h01);
      tick();
      chk_out("c0", 1'b0, 16'hA000, 8'h00, 8'h01, 1'b1, 8'h01);
      tick();
      chk_out("f1", 1'b1, 16'hA001, 8'h01, 8'h02, 1'b0, 8'h02);
      tick();
      tick();
      chk_out("f2", 1'b1, 16'hA002, 8'h02, 8'h03, 1'b0, 8'h03);
      tick(); tick(); tick(); tick();
      tick();
      chk_out("req5", 1'b0, 16'hA004, 8'h04, 8'h05, 1'b1, 8'h05);

      // Hold instruction at pc 5 under stall for 4 cycles
      stall = 1'b1;
      tick();
      chk_out("hold5", 1'b1, 16'hA005, 8'h05, 8'h06, 1'b0, 8'h06);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_out("stall", 1'b1, 16'hA005, 8'h05, 8'h06, 1'b0, 8'h06);
      end
      stall = 1'b0;
      tick();
      chk_out("release", 1'b0, 16'hA005, 8'h05, 8'h06, 1'b1, 8'h06);

      // Redirect in the same cycle as ack drops the data
      redirect = 1'b1;
      redirect_pc = 8'h40;
      chk("redir.ack_present", {31'd0, imem_ack}, 32'd1);
      tick();
      redirect = 1'b0;
      chk_out("redir", 1'b0, 16'hA005, 8'h05, 8'h06, 1'b1, 8'h40);
      tick();
      chk_out("f40", 1'b1, 16'hA040, 8'h40, 8'h41, 1'b0, 8'h41);

      // Redirect out of HOLD to FF, check modulo wrap
      redirect = 1'b1;
      redirect_pc = 8'hFF;
      tick();
      redirect = 1'b0;
      chk_out("redirFF", 1'b0, 16'hA040, 8'h40, 8'h41, 1'b1, 8'hFF);
      tick();
      chk_out("fFF", 1'b1, 16'hA0FF, 8'hFF, 8'h00, 1'b0, 8'h00);
      tick();
      chk_out("wrap", 1'b0, 16'hA0FF, 8'hFF, 8'h00, 1'b1, 8'h00);

      // Reset mid-request, late ack in IDLE is ignored
      rst_n = 1'b0;
      tick();
      chk_out("rst_mid", 1'b0, 16'h0000, 8'h00, 8'h01, 1'b0, 8'h00);
      rst_n = 1'b1;
      ack_en = 1'b0;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      chk_out("late_ack", 1'b0, 16'h0000, 8'h00, 8'h01, 1'b1, 8'h00);
      tick();
      chk_out("no_ack", 1'b0, 16'h0000, 8'h00, 8'h01, 1'b1, 8'h00);
      ack_en = 1'b1;
      tick();
      chk_out("post_rst", 1'b1, 16'hA000, 8'h00, 8'h01, 1'b0, 8'h01);

      // Halt opcode at pc 3
      redirect = 1'b1;
      redirect_pc = 8'h03;
      tick();
      redirect = 1'b0;
      ovr_en = 1'b1;
      ovr_data = 16'hF800;
      tick();
      ovr_en = 1'b0;
      chk_out("fHalt", 1'b1, 16'hF800, 8'h03, 8'h04, 1'b0, 8'h04);
      tick();
`ifdef IFETCH_HALT_EN
      chk("halted", {31'd0, halted}, 32'd1);
      chk_out("halt", 1'b0, 16'hF800, 8'h03, 8'h04, 1'b0, 8'h04);
      tick();
      tick();
      chk("halted2", {31'd0, halted}, 32'd1);
      chk("halt.req", {31'd0, imem_req}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 8'h10;
      tick();
      redirect = 1'b0;
      chk("unhalt", {31'd0, halted}, 32'd0);
      chk_out("resume", 1'b0, 16'hF800, 8'h03, 8'h04, 1'b1, 8'h10);
      tick();
      chk_out("f10", 1'b1, 16'hA010, 8'h10, 8'h11, 1'b0, 8'h11);
`else
      chk_out("nohalt", 1'b0, 16'hF800, 8'h03, 8'h04, 1'b1, 8'h04);
      tick();
      chk_out("f4", 1'b1, 16'hA004, 8'h04, 8'h05, 1'b0, 8'h05);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
